// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] FETCH_STRIDE = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, instr} entries with push, pop, flush and count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head_data,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = push_data;
                tail_d        = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_data = mem_q[head_q];
    assign count     = count_q;

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Fetch front end: credit-limited word requests, in-order response queue, redirect flush.
// Optional INSTR_PREFETCH_BYPASS_EN lets a response reach decode combinationally when the queue is empty.
module instr_prefetch_buffer
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        InstrF_valid,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    input  logic        dec_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    fetch_entry_t  last_q, last_d;

    fetch_entry_t  fifo_head, out_entry;
    logic [CW-1:0] fifo_cnt;
    logic [CW:0]   credit_used;
    logic          fifo_empty, req_fire, resp_drop, resp_take;
    logic          bypass, pop_fire, fifo_push, fifo_pop;

    // Queued plus in-flight never exceeds DEPTH, so every response has a slot.
    assign fifo_empty     = (fifo_cnt == '0);
    assign credit_used    = {1'b0, fifo_cnt} + {1'b0, outstanding_q};
    assign imem_req_valid = reset_n && !redirect && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_drop      = imem_resp_valid && (drop_cnt_q != '0);
    assign resp_take      = imem_resp_valid && !resp_drop && !redirect;

`ifdef INSTR_PREFETCH_BYPASS_EN
    assign bypass = reset_n && resp_take && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    // An empty queue keeps showing the last consumed entry.
    always_comb begin
        InstrF_valid = !fifo_empty;
        out_entry    = fifo_empty ? last_q : fifo_head;
`ifdef INSTR_PREFETCH_BYPASS_EN
        if (bypass) begin
            InstrF_valid = 1'b1;
            out_entry    = {resp_pc_q, imem_resp_data};
        end
`endif
    end

    assign InstrF    = out_entry.instr;
    assign PCF       = out_entry.pc;
    assign pop_fire  = InstrF_valid && dec_ready && !redirect;
    assign fifo_pop  = pop_fire && !fifo_empty;
    assign fifo_push = resp_take && !(bypass && dec_ready);

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data ({resp_pc_q, imem_resp_data}),
        .pop       (fifo_pop),
        .flush     (redirect),
        .head_data (fifo_head),
        .count     (fifo_cnt)
    );

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        last_d        = last_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);
        if (redirect) begin
            // Everything still in flight belongs to the abandoned path.
            fetch_pc_d = align_word(redirect_pc);
            resp_pc_d  = align_word(redirect_pc);
            drop_cnt_d = outstanding_q - CW'(imem_resp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + FETCH_STRIDE;
            end
            if (resp_take) begin
                resp_pc_d = resp_pc_q + FETCH_STRIDE;
            end
            if (resp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (pop_fire) begin
                last_d = out_entry;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            last_q        <= {RESET_PC, NOP_INSTR};
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            last_q        <= last_d;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Self-checking bench for instr_prefetch_buffer: directed scenarios plus randomized stream checking.
module tb_instr_prefetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef INSTR_PREFETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk;
    logic        reset_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        InstrF_valid;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic        dec_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_fail = 0;

    instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .InstrF_valid    (InstrF_valid),
        .InstrF          (InstrF),
        .PCF             (PCF),
        .dec_ready       (dec_ready),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h3C5A_96E1;
    endfunction

    // In-order memory with per-request latency, reset together with the DUT.
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mem_q[$];
    mreq_t mem_tmp;
    int    cyc = 0;
    int    mem_lat_min = 1;
    int    mem_lat_max = 1;
    int    ready_pct = 100;

    initial begin
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset_n) begin
                mem_q.delete();
            end else if (imem_req_valid && imem_req_ready) begin
                mem_tmp.addr = imem_req_addr;
                mem_tmp.due  = cyc + int'($urandom_range(mem_lat_max, mem_lat_min)) - 1;
                mem_q.push_back(mem_tmp);
            end
            #1;
            imem_resp_valid = 1'b0;
            if (reset_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(mem_q[0].addr);
                void'(mem_q.pop_front());
            end
            imem_req_ready = (int'($urandom_range(99)) < ready_pct);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        dec_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (InstrF_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", InstrF_valid); end
        n_cmp++; if (InstrF !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr: got %h want 00000013", InstrF); end
        n_cmp++; if (PCF !== RESET_PC) begin n_fail++; $display("FAIL reset_pcf: got %h want %h", PCF, RESET_PC); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_reqv: got %b want 0", imem_req_valid); end
        do_reset();
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL first_reqv: got %b want 1", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL first_addr: got %h want %h", imem_req_addr, RESET_PC); end
    endtask

    task automatic test_stream();
        logic [31:0] ea, ep;
        mem_lat_min = 1; mem_lat_max = 1; ready_pct = 100;
        do_reset();
        dec_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            ea = 32'(4 * (c - 1));
            n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== ea) begin n_fail++; $display("FAIL stream_req c%0d: got %b/%h want 1/%h", c, imem_req_valid, imem_req_addr, ea); end
            n_cmp++; if (InstrF_valid !== (c >= 3 - BYP)) begin n_fail++; $display("FAIL stream_valid c%0d: got %b want %b", c, InstrF_valid, c >= 3 - BYP); end
            if (c >= 3 - BYP) begin
                ep = 32'(4 * (c - 3 + BYP));
                n_cmp++; if (PCF !== ep || InstrF !== mem_word(ep)) begin n_fail++; $display("FAIL stream_out c%0d: got %h/%h want %h/%h", c, PCF, InstrF, ep, mem_word(ep)); end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int got = 0;
        logic [31:0] ep = 32'h0;
        mem_lat_min = 1; mem_lat_max = 1; ready_pct = 100;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) acc++;
            step();
        end
        @(negedge clk);
        n_cmp++; if (acc !== 4) begin n_fail++; $display("FAIL bp_accepts: got %0d want 4", acc); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_reqv: got %b want 0", imem_req_valid); end
        n_cmp++; if (InstrF_valid !== 1'b1 || PCF !== 32'h0) begin n_fail++; $display("FAIL bp_hold: got %b/%h want 1/00000000", InstrF_valid, PCF); end
        step();
        dec_ready = 1'b1;
        for (int i = 0; i < 40 && got < 6; i++) begin
            @(negedge clk);
            if (InstrF_valid) begin
                n_cmp++; if (PCF !== ep || InstrF !== mem_word(ep)) begin n_fail++; $display("FAIL bp_drain: got %h/%h want %h/%h", PCF, InstrF, ep, mem_word(ep)); end
                ep += 32'd4;
                got++;
            end
            step();
        end
        n_cmp++; if (got !== 6) begin n_fail++; $display("FAIL bp_drain_count: got %0d want 6", got); end
    endtask

    task automatic wait_first_valid(input string nm, input logic [31:0] ep);
        bit found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (InstrF_valid) begin found = 1; break; end
            step();
        end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL %s_timeout: got no valid want valid", nm); end
        n_cmp++; if (PCF !== ep || InstrF !== mem_word(ep)) begin n_fail++; $display("FAIL %s_target: got %h/%h want %h/%h", nm, PCF, InstrF, ep, mem_word(ep)); end
    endtask

    task automatic test_redirect_drop();
        mem_lat_min = 6; mem_lat_max = 6; ready_pct = 100;
        do_reset();
        dec_ready = 1'b1;
        for (int i = 0; i < 20 && mem_q.size() != 3; i++) step();
        n_cmp++; if (mem_q.size() != 3) begin n_fail++; $display("FAIL rd_inflight: got %0d want 3", mem_q.size()); end
        redirect = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rd_no_req: got %b want 0", imem_req_valid); end
        step();
        redirect = 1'b0;
        @(negedge clk);
        n_cmp++; if (InstrF_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid: got %b want 0", InstrF_valid); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL rd_req: got %b/%h want 1/00000100", imem_req_valid, imem_req_addr); end
        n_cmp++; if (int'(dut.drop_cnt_q) != 3) begin n_fail++; $display("FAIL rd_drop: got %0d want 3", dut.drop_cnt_q); end
        step();
        wait_first_valid("rd", 32'h100);
    endtask

    task automatic test_redirect_same_cycle();
        int drop_exp;
        mem_lat_min = 2; mem_lat_max = 2; ready_pct = 100;
        do_reset();
        dec_ready = 1'b1;
        repeat (5) step();
        drop_exp = mem_q.size();
        redirect = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        n_cmp++; if (imem_resp_valid !== 1'b1 || drop_exp != 1) begin n_fail++; $display("FAIL rs_setup: got resp %b inflight %0d want 1/1", imem_resp_valid, drop_exp); end
`ifndef INSTR_PREFETCH_BYPASS_EN
        n_cmp++; if (InstrF_valid !== 1'b1) begin n_fail++; $display("FAIL rs_pop_present: got %b want 1", InstrF_valid); end
`endif
        step();
        redirect = 1'b0;
        @(negedge clk);
        n_cmp++; if (InstrF_valid !== 1'b0) begin n_fail++; $display("FAIL rs_valid: got %b want 0", InstrF_valid); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL rs_req: got %b/%h want 1/00000100", imem_req_valid, imem_req_addr); end
        n_cmp++; if (int'(dut.drop_cnt_q) != drop_exp) begin n_fail++; $display("FAIL rs_drop: got %0d want %0d", dut.drop_cnt_q, drop_exp); end
        step();
        wait_first_valid("rs", 32'h100);
    endtask

    task automatic test_misaligned();
        mem_lat_min = 1; mem_lat_max = 1; ready_pct = 100;
        do_reset();
        dec_ready = 1'b1;
        repeat (3) step();
        redirect = 1'b1; redirect_pc = 32'h102;
        step();
        redirect = 1'b0;
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL mis_req: got %b/%h want 1/00000100", imem_req_valid, imem_req_addr); end
        step();
        wait_first_valid("mis", 32'h100);
    endtask

    task automatic test_wrap_and_reset();
        logic [31:0] ea = 32'hFFFF_FFF8;
        logic [31:0] ep = 32'hFFFF_FFF8;
        int got = 0;
        mem_lat_min = 1; mem_lat_max = 1; ready_pct = 100;
        do_reset();
        dec_ready = 1'b1;
        repeat (2) step();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== ea) begin n_fail++; $display("FAIL wrap_req %0d: got %b/%h want 1/%h", i, imem_req_valid, imem_req_addr, ea); end
            if (InstrF_valid) begin
                n_cmp++; if (PCF !== ep || InstrF !== mem_word(ep)) begin n_fail++; $display("FAIL wrap_out: got %h/%h want %h/%h", PCF, InstrF, ep, mem_word(ep)); end
                ep += 32'd4;
                got++;
            end
            ea += 32'd4;
            step();
        end
        n_cmp++; if (got < 3) begin n_fail++; $display("FAIL wrap_count: got %0d want >=3", got); end
        reset_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (InstrF_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL midreset: got %b/%b want 0/0", InstrF_valid, imem_req_valid); end
        repeat (2) step();
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC || InstrF_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset: got %b/%h/%b want 1/%h/0", imem_req_valid, imem_req_addr, InstrF_valid, RESET_PC); end
        step();
    endtask

    // Reference: decode sees one consecutive PC stream per redirect, data matching memory.
    task automatic test_random();
        logic [31:0] exp_pc = RESET_PC;
        logic [31:0] exp_req = RESET_PC;
        logic [31:0] hold_pc = '0, hold_instr = '0;
        bit hold = 0;
        int delivered = 0;
        mem_lat_min = 1; mem_lat_max = 4; ready_pct = 70;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (hold) begin
                n_cmp++; if (InstrF_valid !== 1'b1 || PCF !== hold_pc || InstrF !== hold_instr) begin n_fail++; $display("FAIL rnd_stable cyc %0d: got %b/%h/%h want 1/%h/%h", i, InstrF_valid, PCF, InstrF, hold_pc, hold_instr); end
            end
            if (redirect) begin
                n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_redir_req cyc %0d: got %b want 0", i, imem_req_valid); end
                exp_pc  = {redirect_pc[31:2], 2'b00};
                exp_req = {redirect_pc[31:2], 2'b00};
            end else begin
                if (InstrF_valid && dec_ready) begin
                    n_cmp++; if (PCF !== exp_pc || InstrF !== mem_word(exp_pc)) begin n_fail++; $display("FAIL rnd_deliver cyc %0d: got %h/%h want %h/%h", i, PCF, InstrF, exp_pc, mem_word(exp_pc)); end
                    exp_pc += 32'd4;
                    delivered++;
                end
                if (imem_req_valid && imem_req_ready) begin
                    n_cmp++; if (imem_req_addr !== exp_req) begin n_fail++; $display("FAIL rnd_req cyc %0d: got %h want %h", i, imem_req_addr, exp_req); end
                    exp_req += 32'd4;
                end
            end
            n_cmp++; if (mem_q.size() + int'(imem_resp_valid) > DEPTH) begin n_fail++; $display("FAIL rnd_credit cyc %0d: got %0d in flight want <=%0d", i, mem_q.size() + int'(imem_resp_valid), DEPTH); end
            hold       = InstrF_valid && !dec_ready && !redirect;
            hold_pc    = PCF;
            hold_instr = InstrF;
            step();
            dec_ready = ($urandom_range(99) < 75);
            redirect  = ($urandom_range(99) < 4);
            case ($urandom_range(2))
                0:       redirect_pc = $urandom();
                1:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
                default: redirect_pc = 32'h100 + 32'($urandom_range(7));
            endcase
        end
        redirect = 1'b0;
        n_cmp++; if (delivered < 500) begin n_fail++; $display("FAIL rnd_progress: got %0d want >=500", delivered); end
    endtask

    initial begin
        reset_n     = 1'b0;
        dec_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_same_cycle();
        test_misaligned();
        test_wrap_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
